// File: rtl/dsp_fe_lut_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// dsp_fe_lut_cfg_ctrl
//
// Configuration sequencer for one DSP-FE ADC-calibration LUT lane. Table
// writes land in a shadow table through a valid/ready port. Commit and seed
// commands run a drain/apply/settle sequence on the LUT mode inputs, so a
// table can be rewritten without glitching mission-mode output. The shadow
// table is also presented packed on o_cfg_table for the LUT to consume.
//
// Parameters:
//   INPUT_WIDTH    LUT address width (table holds 2**INPUT_WIDTH entries)
//   OUTPUT_WIDTH   LUT entry width
//   SETTLE_CYCLES  drain and settle wait length, legal 1..15; set it to at
//                  least the LUT pipeline depth
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready   shadow-table write handshake
//   i_wr_addr, i_wr_data    entry index and value
//   i_cmd_commit            pulse: apply the shadow table through load mode
//   i_cmd_seed              pulse: apply the default table through seed mode
//   i_mission_en            level: run the LUT in mission mode when idle
//   o_cfg_mode_load/seed/mission  registered, mutually exclusive LUT modes
//   o_cfg_table             packed shadow table, entry 0 in the MSBs
//   o_busy                  high during DRAIN, APPLY and SETTLE
//   o_done                  one-cycle pulse in the last SETTLE cycle
//   o_wr_count              writes accepted since last commit, saturating
//
// Optional feature (macro DSP_FE_LUT_CFG_READBACK_EN):
//   i_rd_addr, o_rd_data    registered shadow-table readback, 1-cycle latency
// ---------------------------------------------------------------------------
module dsp_fe_lut_cfg_ctrl #(
    parameter int INPUT_WIDTH   = 6,
    parameter int OUTPUT_WIDTH  = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_wr_valid,
    output logic                                       o_wr_ready,
    input  logic [INPUT_WIDTH-1:0]                     i_wr_addr,
    input  logic [OUTPUT_WIDTH-1:0]                    i_wr_data,
    input  logic                                       i_cmd_commit,
    input  logic                                       i_cmd_seed,
    input  logic                                       i_mission_en,
`ifdef DSP_FE_LUT_CFG_READBACK_EN
    input  logic [INPUT_WIDTH-1:0]                     i_rd_addr,
    output logic [OUTPUT_WIDTH-1:0]                    o_rd_data,
`endif
    output logic                                       o_cfg_mode_load,
    output logic                                       o_cfg_mode_seed,
    output logic                                       o_cfg_mode_mission,
    output logic [(2**INPUT_WIDTH)*OUTPUT_WIDTH-1:0]   o_cfg_table,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic [INPUT_WIDTH:0]                       o_wr_count
);

    localparam int DEPTH = 2**INPUT_WIDTH;

    // Counter is preloaded with SETTLE_CYCLES-1 and runs down to zero, so a
    // phase lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    // Saturation value 2**INPUT_WIDTH for the write counter.
    localparam logic [INPUT_WIDTH:0] WR_MAX = {1'b1, {INPUT_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISSION,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    cmd_is_commit;
    logic                    busy_q;
    logic                    wr_accept;
    logic                    cmd_any;
    logic [OUTPUT_WIDTH-1:0] entry_q [DEPTH];

    assign o_busy     = busy_q;
    assign o_wr_ready = !busy_q;
    assign wr_accept  = i_wr_valid && !busy_q;
    assign cmd_any    = i_cmd_commit || i_cmd_seed;

    // Shadow table. Writes are blocked while busy, which keeps o_cfg_table
    // stable across the whole drain/apply/settle sequence.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
        end else if (wr_accept) begin
            entry_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Entry k is packed at slice (DEPTH-1-k), placing entry 0 in the MSBs to
    // match the LUT's left-to-right unpack.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign o_cfg_table[(DEPTH-1-g)*OUTPUT_WIDTH +: OUTPUT_WIDTH] = entry_q[g];
    end

    // Sequencer with registered mode, busy and done outputs, plus the write
    // counter (cleared on entry to APPLY for a commit).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            cmd_is_commit      <= 1'b0;
            busy_q             <= 1'b0;
            o_cfg_mode_load    <= 1'b0;
            o_cfg_mode_seed    <= 1'b0;
            o_cfg_mode_mission <= 1'b0;
            o_done             <= 1'b0;
            o_wr_count         <= '0;
        end else begin
            o_done <= 1'b0;

            if (wr_accept && (o_wr_count != WR_MAX)) begin
                o_wr_count <= o_wr_count + 1'b1;
            end

            case (state)
                ST_IDLE, ST_MISSION: begin
                    if (cmd_any) begin
                        // Commit wins over seed, matching the LUT's
                        // load-over-seed priority.
                        state              <= ST_DRAIN;
                        cnt                <= CNT_LOAD;
                        cmd_is_commit      <= i_cmd_commit;
                        busy_q             <= 1'b1;
                        o_cfg_mode_mission <= 1'b0;
                    end else if (state == ST_IDLE && i_mission_en) begin
                        state              <= ST_MISSION;
                        o_cfg_mode_mission <= 1'b1;
                    end else if (state == ST_MISSION && !i_mission_en) begin
                        state              <= ST_IDLE;
                        o_cfg_mode_mission <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    if (cnt == 4'd0) begin
                        state           <= ST_APPLY;
                        o_cfg_mode_load <= cmd_is_commit;
                        o_cfg_mode_seed <= !cmd_is_commit;
                        if (cmd_is_commit) begin
                            o_wr_count <= '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_APPLY: begin
                    state           <= ST_SETTLE;
                    o_cfg_mode_load <= 1'b0;
                    o_cfg_mode_seed <= 1'b0;
                    cnt             <= CNT_LOAD;
                    o_done          <= (CNT_LOAD == 4'd0);
                end

                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        // Mission enable is only sampled here while busy.
                        busy_q             <= 1'b0;
                        state              <= i_mission_en ? ST_MISSION : ST_IDLE;
                        o_cfg_mode_mission <= i_mission_en;
                    end else begin
                        cnt    <= cnt - 4'd1;
                        o_done <= (cnt == 4'd1);
                    end
                end

                default: begin
                    state              <= ST_IDLE;
                    busy_q             <= 1'b0;
                    o_cfg_mode_load    <= 1'b0;
                    o_cfg_mode_seed    <= 1'b0;
                    o_cfg_mode_mission <= 1'b0;
                end
            endcase
        end
    end

`ifdef DSP_FE_LUT_CFG_READBACK_EN
    // Registered readback; a same-cycle write to the read address returns
    // the old entry because the table updates on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= entry_q[i_rd_addr];
        end
    end
`else
    // No readback path in this build.
`endif

endmodule

// File: tb/tb_dsp_fe_lut_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dsp_fe_lut_cfg_ctrl
//
// Directed testbench for dsp_fe_lut_cfg_ctrl with the default parameters
// (INPUT_WIDTH=6, OUTPUT_WIDTH=6, SETTLE_CYCLES=2). Inputs are driven and
// outputs sampled on the falling clock edge.
//
// Sequence cycle numbering: cycle c is the cycle after the c-th rising edge
// counted from the edge that accepts a command. With SETTLE_CYCLES=2:
//   c=1,2 DRAIN   c=3 APPLY   c=4,5 SETTLE (done at 5)   c=6 IDLE/MISSION
// ---------------------------------------------------------------------------
module tb_dsp_fe_lut_cfg_ctrl;

    localparam int IW = 6;
    localparam int OW = 6;
    localparam int TW = 64 * 6;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_wr_valid = 1'b0;
    logic          o_wr_ready;
    logic [IW-1:0] i_wr_addr = '0;
    logic [OW-1:0] i_wr_data = '0;
    logic          i_cmd_commit = 1'b0;
    logic          i_cmd_seed = 1'b0;
    logic          i_mission_en = 1'b0;
`ifdef DSP_FE_LUT_CFG_READBACK_EN
    logic [IW-1:0] i_rd_addr = '0;
    logic [OW-1:0] o_rd_data;
`endif
    logic          o_cfg_mode_load;
    logic          o_cfg_mode_seed;
    logic          o_cfg_mode_mission;
    logic [TW-1:0] o_cfg_table;
    logic          o_busy;
    logic          o_done;
    logic [IW:0]   o_wr_count;

    int tests_run = 0;
    int tests_failed = 0;

    dsp_fe_lut_cfg_ctrl #(
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .SETTLE_CYCLES(2)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_wr_valid        (i_wr_valid),
        .o_wr_ready        (o_wr_ready),
        .i_wr_addr         (i_wr_addr),
        .i_wr_data         (i_wr_data),
        .i_cmd_commit      (i_cmd_commit),
        .i_cmd_seed        (i_cmd_seed),
        .i_mission_en      (i_mission_en),
`ifdef DSP_FE_LUT_CFG_READBACK_EN
        .i_rd_addr         (i_rd_addr),
        .o_rd_data         (o_rd_data),
`endif
        .o_cfg_mode_load   (o_cfg_mode_load),
        .o_cfg_mode_seed   (o_cfg_mode_seed),
        .o_cfg_mode_mission(o_cfg_mode_mission),
        .o_cfg_table       (o_cfg_table),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_wr_count        (o_wr_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Control outputs packed as {busy, load, seed, mission, done, ready}.
    function automatic logic [5:0] observed();
        return {o_busy, o_cfg_mode_load, o_cfg_mode_seed,
                o_cfg_mode_mission, o_done, o_wr_ready};
    endfunction

    // Expected control outputs for sequence cycle c (SETTLE_CYCLES=2).
    function automatic logic [5:0] exp_seq(int c, bit is_commit, bit mis);
        logic busy;
        busy = (c >= 1) && (c <= 5);
        return {busy, is_commit && (c == 3), !is_commit && (c == 3),
                mis && (c == 6), (c == 5), !busy};
    endfunction

    function automatic logic [OW-1:0] entry(int k);
        return o_cfg_table[(63 - k) * OW +: OW];
    endfunction

    task automatic write_entry(input logic [IW-1:0] a, input logic [OW-1:0] d);
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        @(negedge i_clk);
        i_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (observed() !== 6'b000001) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", observed(), 6'b000001);
        end
        tests_run++;
        if (o_cfg_table !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_table: got nonzero table expected 0");
        end
        tests_run++;
        if (o_wr_count !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wr_count: got %0d expected 0", o_wr_count);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (observed() !== 6'b000001) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got %b expected %b", observed(), 6'b000001);
        end
    endtask

    task automatic test_commit();
        logic [TW-1:0] exp_tbl;
        exp_tbl = '0;
        exp_tbl[383:378] = 6'h3F;
        exp_tbl[5:0] = 6'h01;
        write_entry(6'd0, 6'h3F);
        write_entry(6'd63, 6'h01);
        tests_run++;
        if (o_wr_count !== 7'd2) begin
            tests_failed++;
            $display("[TB] FAIL commit_wr_count_pre: got %0d expected 2", o_wr_count);
        end
        tests_run++;
        if (o_cfg_table[383:378] !== 6'h3F || o_cfg_table[5:0] !== 6'h01) begin
            tests_failed++;
            $display("[TB] FAIL commit_pack: got msb %h lsb %h expected 3f 01",
                     o_cfg_table[383:378], o_cfg_table[5:0]);
        end
        tests_run++;
        if (o_cfg_table !== exp_tbl) begin
            tests_failed++;
            $display("[TB] FAIL commit_table: other entries not zero");
        end
        i_cmd_commit = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            if (c == 1) i_cmd_commit = 1'b0;
            tests_run++;
            if (observed() !== exp_seq(c, 1'b1, 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL commit_seq c=%0d: got %b expected %b",
                         c, observed(), exp_seq(c, 1'b1, 1'b0));
            end
            if (c == 2) begin
                tests_run++;
                if (o_wr_count !== 7'd2) begin
                    tests_failed++;
                    $display("[TB] FAIL commit_wr_count_drain: got %0d expected 2", o_wr_count);
                end
            end
            if (c == 3) begin
                tests_run++;
                if (o_wr_count !== 7'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL commit_wr_count_apply: got %0d expected 0", o_wr_count);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (o_cfg_table !== exp_tbl) begin
                    tests_failed++;
                    $display("[TB] FAIL commit_table_stable: table changed during sequence");
                end
            end
        end
    endtask

    task automatic test_seed_mission();
        write_entry(6'd7, 6'h15);
        i_mission_en = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (observed() !== 6'b000101) begin
            tests_failed++;
            $display("[TB] FAIL mission_enter: got %b expected %b", observed(), 6'b000101);
        end
        i_cmd_seed = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            if (c == 1) i_cmd_seed = 1'b0;
            tests_run++;
            if (observed() !== exp_seq(c, 1'b0, 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL seed_seq c=%0d: got %b expected %b",
                         c, observed(), exp_seq(c, 1'b0, 1'b1));
            end
        end
        tests_run++;
        if (o_wr_count !== 7'd1) begin
            tests_failed++;
            $display("[TB] FAIL seed_keeps_count: got %0d expected 1", o_wr_count);
        end
        tests_run++;
        if (entry(7) !== 6'h15 || entry(0) !== 6'h3F) begin
            tests_failed++;
            $display("[TB] FAIL seed_table: got e7 %h e0 %h expected 15 3f", entry(7), entry(0));
        end
        i_mission_en = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (observed() !== 6'b000001) begin
            tests_failed++;
            $display("[TB] FAIL mission_exit: got %b expected %b", observed(), 6'b000001);
        end
    endtask

    task automatic test_back_to_back();
        // Commit and seed together, with a same-cycle write to entry 1.
        i_cmd_commit = 1'b1;
        i_cmd_seed   = 1'b1;
        i_wr_valid   = 1'b1;
        i_wr_addr    = 6'd1;
        i_wr_data    = 6'h2B;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            tests_run++;
            if (observed() !== exp_seq(c, 1'b1, 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL both_seq c=%0d: got %b expected %b",
                         c, observed(), exp_seq(c, 1'b1, 1'b0));
            end
            if (c == 2) begin
                tests_run++;
                if (o_wr_count !== 7'd2) begin
                    tests_failed++;
                    $display("[TB] FAIL both_wr_count: got %0d expected 2", o_wr_count);
                end
            end
            // Writes to entry 10 and extra commands while busy must be ignored.
            case (c)
                1: begin
                    i_cmd_commit = 1'b0;
                    i_cmd_seed   = 1'b0;
                    i_wr_addr    = 6'd10;
                    i_wr_data    = 6'h15;
                end
                2: i_cmd_commit = 1'b1;
                3: begin i_cmd_commit = 1'b0; i_cmd_seed = 1'b1; end
                4: begin i_cmd_seed = 1'b0; i_cmd_commit = 1'b1; end
                5: begin i_cmd_commit = 1'b0; i_cmd_seed = 1'b1; i_wr_valid = 1'b0; end
                default: i_cmd_seed = 1'b0;
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            tests_run++;
            if (o_busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy_cmd_ignored k=%0d: got busy %b expected 0", k, o_busy);
            end
        end
        tests_run++;
        if (entry(1) !== 6'h2B) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_write: got %h expected 2b", entry(1));
        end
        tests_run++;
        if (entry(10) !== 6'h00) begin
            tests_failed++;
            $display("[TB] FAIL busy_write_blocked: got %h expected 00", entry(10));
        end
        tests_run++;
        if (o_wr_count !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL busy_write_count: got %0d expected 0", o_wr_count);
        end
    endtask

    task automatic test_saturation();
        logic [TW-1:0] exp_tbl;
        for (int i = 0; i < 70; i++) begin
            write_entry(6'(i % 64), 6'(i));
            if (i == 62) begin
                tests_run++;
                if (o_wr_count !== 7'd63) begin
                    tests_failed++;
                    $display("[TB] FAIL wr_count_63: got %0d expected 63", o_wr_count);
                end
            end
        end
        tests_run++;
        if (o_wr_count !== 7'd64) begin
            tests_failed++;
            $display("[TB] FAIL wr_count_saturate: got %0d expected 64", o_wr_count);
        end
        // Entry k ends up holding k: the wrapped writes 64..69 store 0..5.
        for (int k = 0; k < 64; k++) begin
            exp_tbl[(63 - k) * OW +: OW] = 6'(k);
        end
        tests_run++;
        if (o_cfg_table !== exp_tbl) begin
            tests_failed++;
            $display("[TB] FAIL saturate_table: got e5 %h e63 %h expected 05 3f",
                     entry(5), entry(63));
        end
    endtask

    task automatic test_reset_mid_apply();
        i_cmd_commit = 1'b1;
        @(negedge i_clk);
        i_cmd_commit = 1'b0;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (o_cfg_mode_load !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL apply_load: got %b expected 1", o_cfg_mode_load);
        end
        #2 i_rst_n = 1'b0;
        #1;
        tests_run++;
        if (observed() !== 6'b000001) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_ctrl: got %b expected %b", observed(), 6'b000001);
        end
        tests_run++;
        if (o_cfg_table !== '0 || o_wr_count !== 7'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_table: got count %0d expected table 0 count 0", o_wr_count);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if (observed() !== 6'b000001) begin
            tests_failed++;
            $display("[TB] FAIL after_async_reset: got %b expected %b", observed(), 6'b000001);
        end
    endtask

`ifdef DSP_FE_LUT_CFG_READBACK_EN
    task automatic test_readback();
        write_entry(6'd5, 6'h2A);
        i_rd_addr = 6'd5;
        @(negedge i_clk);
        tests_run++;
        if (o_rd_data !== 6'h2A) begin
            tests_failed++;
            $display("[TB] FAIL readback: got %h expected 2a", o_rd_data);
        end
        i_wr_valid = 1'b1;
        i_wr_addr  = 6'd5;
        i_wr_data  = 6'h11;
        @(negedge i_clk);
        i_wr_valid = 1'b0;
        tests_run++;
        if (o_rd_data !== 6'h2A) begin
            tests_failed++;
            $display("[TB] FAIL readback_old: got %h expected 2a", o_rd_data);
        end
        @(negedge i_clk);
        tests_run++;
        if (o_rd_data !== 6'h11) begin
            tests_failed++;
            $display("[TB] FAIL readback_new: got %h expected 11", o_rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_commit();
        test_seed_mission();
        test_back_to_back();
        test_saturation();
        test_reset_mid_apply();
`ifdef DSP_FE_LUT_CFG_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
